// File: rtl/alu_result_buffer_if.sv
// Handshake and payload bundle between the ALU, the result buffer and writeback.
// Also carries the architectural status outputs.
interface alu_result_buffer_if;
  localparam int unsigned RESULT_W = 32;
  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned FLAGS_W  = 4;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned OVFCNT_W = 8;

  logic                in_valid;
  logic                in_ready;
  logic [RESULT_W-1:0] in_result;
  logic [FUNC_W-1:0]   in_func;
  logic [FLAGS_W-1:0]  in_flags;
  logic [RD_W-1:0]     in_rd;
  logic                flush;

  logic                out_valid;
  logic                out_ready;
  logic [RESULT_W-1:0] out_result;
  logic [RD_W-1:0]     out_rd;
  logic                out_wen;
  logic                out_ovf_exc;
  logic [FLAGS_W-1:0]  status_flags;
  logic [OVFCNT_W-1:0] ovf_count;

  modport master (
    output in_valid, in_result, in_func, in_flags, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wen, out_ovf_exc,
           status_flags, ovf_count
  );

  modport slave (
    input  in_valid, in_result, in_func, in_flags, in_rd, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wen, out_ovf_exc,
           status_flags, ovf_count
  );
endinterface

// File: rtl/alu_result_buffer.sv
// FIFO between the ALU and register writeback; classifies overflow exceptions,
// maintains the architectural {C,N,Z,V} status register and a saturating overflow count.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  alu_result_buffer_if.slave  bus
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned RESULT_W = 32;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned FLAGS_W  = 4;
  localparam int unsigned OVFCNT_W = 8;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SLLV = 6'b000100;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRLV = 6'b000110;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic [RD_W-1:0]     rd;
    logic                wen;
    logic                ovf;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [FLAGS_W-1:0]  status_q, status_d;
  logic [OVFCNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic   full_c, empty_c, push_c, pop_c;
  logic   is_addsub_c, is_carry_only_c;
  entry_t in_entry_c, head_c;

  // Handshake decode; flush suppresses both sides of the transfer
  always_comb begin
    full_c  = (count_q == CNT_W'(DEPTH));
    empty_c = (count_q == CNT_W'(0));
    push_c  = bus.in_valid && !full_c && !bus.flush;
    pop_c   = !empty_c && bus.out_ready && !bus.flush;
  end

  // Function-code classification and the entry that a push would store
  always_comb begin
    is_addsub_c     = 1'b0;
    is_carry_only_c = 1'b0;
    case (bus.in_func)
      FUNC_ADD, FUNC_SUB:                      is_addsub_c     = 1'b1;
      FUNC_ADDU, FUNC_SUBU, FUNC_SLL,
      FUNC_SLLV, FUNC_SRL, FUNC_SRLV:          is_carry_only_c = 1'b1;
      default: ;
    endcase
    in_entry_c.result = bus.in_result;
    in_entry_c.rd     = bus.in_rd;
    in_entry_c.ovf    = is_addsub_c && bus.in_flags[0];
    in_entry_c.wen    = (bus.in_rd != RD_W'(0)) && !in_entry_c.ovf;
  end

  // Next-state for storage, pointers, occupancy, status and exception count
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    status_d  = status_q;
    ovf_cnt_d = ovf_cnt_q;

    if (bus.flush) begin
      rd_ptr_d = PTR_W'(0);
      wr_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      if (push_c) begin
        mem_d[wr_ptr_q] = in_entry_c;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // Status and overflow count only move on an accepted push
    if (push_c) begin
      if (is_addsub_c) begin
        status_d[2:0] = bus.in_flags[2:0];
      end
      if (is_carry_only_c) begin
        status_d[3] = bus.in_flags[3];
      end
      if (in_entry_c.ovf && (ovf_cnt_q != {OVFCNT_W{1'b1}})) begin
        ovf_cnt_d = ovf_cnt_q + OVFCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= PTR_W'(0);
      wr_ptr_q  <= PTR_W'(0);
      count_q   <= CNT_W'(0);
      status_q  <= FLAGS_W'(0);
      ovf_cnt_q <= OVFCNT_W'(0);
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      status_q  <= status_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Payload storage needs no reset: it is only observable while count is nonzero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head entry is forced to zero while the buffer is empty
  always_comb begin
    head_c           = mem_q[rd_ptr_q];
    bus.in_ready     = !full_c;
    bus.out_valid    = !empty_c;
    bus.out_result   = empty_c ? RESULT_W'(0) : head_c.result;
    bus.out_rd       = empty_c ? RD_W'(0)     : head_c.rd;
    bus.out_wen      = !empty_c && head_c.wen;
    bus.out_ovf_exc  = !empty_c && head_c.ovf;
    bus.status_flags = status_q;
    bus.ovf_count    = ovf_cnt_q;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: vector table plus multi-cycle sequences,
// with a queue scoreboard and a small reference model for status and overflow count.
module tb_alu_result_buffer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_result_buffer_if bus ();

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [5:0]  func;
    logic [3:0]  flags;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        exp_wen;
    logic        exp_ovf;
    logic [3:0]  exp_status;
    logic [7:0]  exp_ovf_cnt;
  } vec_t;

  exp_t       sbq[$];
  int         mcount;
  logic [3:0] mstatus;
  logic [7:0] movf;
  int         n_pass;
  int         n_tot;
  vec_t       vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic exp_t model_entry(input logic [5:0] f, input logic [3:0] fl,
                                       input logic [4:0] rd, input logic [31:0] r);
    exp_t e;
    e.result = r;
    e.rd     = rd;
    e.ovf    = ((f == 6'h20) || (f == 6'h22)) && fl[0];
    e.wen    = (rd != 5'd0) && !e.ovf;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [5:0] f, input logic [3:0] fl,
                       input logic [4:0] rd, input logic [31:0] r);
    bus.in_valid  = v;
    bus.in_func   = f;
    bus.in_flags  = fl;
    bus.in_rd     = rd;
    bus.in_result = r;
  endtask

  // Check this cycle's outputs, update the model for the coming edge, then advance
  task automatic step();
    bit   acc;
    bit   pop;
    exp_t h;
    exp_t e;
    acc = bus.in_valid && !bus.flush && !reset && (mcount != DEPTH);
    pop = bus.out_ready && !bus.flush && !reset && (mcount != 0);
    chk("in_ready", 32'(bus.in_ready), 32'(mcount != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(mcount != 0));
    if (mcount == 0) begin
      chk("idle_out_result", bus.out_result, 32'h0);
      chk("idle_out_side", 32'({bus.out_rd, bus.out_wen, bus.out_ovf_exc}), 32'h0);
    end
    if (pop) begin
      h = sbq.pop_front();
      chk("head_result", bus.out_result, h.result);
      chk("head_rd", 32'(bus.out_rd), 32'(h.rd));
      chk("head_wen", 32'(bus.out_wen), 32'(h.wen));
      chk("head_ovf", 32'(bus.out_ovf_exc), 32'(h.ovf));
    end
    if (acc) begin
      e = model_entry(bus.in_func, bus.in_flags, bus.in_rd, bus.in_result);
      sbq.push_back(e);
      case (bus.in_func)
        6'h20, 6'h22: mstatus[2:0] = bus.in_flags[2:0];
        6'h21, 6'h23, 6'h00, 6'h04, 6'h02, 6'h06: mstatus[3] = bus.in_flags[3];
        default: ;
      endcase
      if (e.ovf && movf != 8'hFF) movf = movf + 8'd1;
    end
    if (reset) begin
      sbq.delete();
      mcount  = 0;
      mstatus = 4'h0;
      movf    = 8'h00;
    end else if (bus.flush) begin
      sbq.delete();
      mcount = 0;
    end else begin
      mcount = mcount + int'(acc) - int'(pop);
    end
    @(posedge clk);
    #1;
    chk("status_flags", 32'(bus.status_flags), 32'(mstatus));
    chk("ovf_count", 32'(bus.ovf_count), 32'(movf));
  endtask

  task automatic drain(input string nm);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4 * DEPTH && mcount != 0; c++) step();
    chk(nm, 32'(mcount), 32'h0);
  endtask

  initial begin
    n_pass  = 0;
    n_tot   = 0;
    mcount  = 0;
    mstatus = 4'h0;
    movf    = 8'h00;

    //               func   flags    rd     result        wen   ovf   status   ovfcnt
    vecs[0] = '{6'h20, 4'b0000, 5'd3,  32'h0000_0005, 1'b1, 1'b0, 4'b0000, 8'd0};
    vecs[1] = '{6'h20, 4'b0001, 5'd8,  32'h8000_0000, 1'b0, 1'b1, 4'b0001, 8'd1};
    vecs[2] = '{6'h23, 4'b1110, 5'd4,  32'h0000_0010, 1'b1, 1'b0, 4'b1001, 8'd1};
    vecs[3] = '{6'h23, 4'b0001, 5'd5,  32'h0000_0011, 1'b1, 1'b0, 4'b0001, 8'd1};
    vecs[4] = '{6'h24, 4'b1111, 5'd6,  32'h0000_0012, 1'b1, 1'b0, 4'b0001, 8'd1};
    vecs[5] = '{6'h22, 4'b0110, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 4'b0110, 8'd1};
    vecs[6] = '{6'h00, 4'b1000, 5'd1,  32'h0000_0100, 1'b1, 1'b0, 4'b1110, 8'd1};
    vecs[7] = '{6'h06, 4'b0000, 5'd31, 32'h0000_0001, 1'b1, 1'b0, 4'b0110, 8'd1};
    vecs[8] = '{6'h22, 4'b1011, 5'd2,  32'hFFFF_FFF0, 1'b0, 1'b1, 4'b0011, 8'd2};
    vecs[9] = '{6'h21, 4'b1001, 5'd7,  32'h0000_0042, 1'b1, 1'b0, 4'b1011, 8'd2};

    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 6'h00, 4'h0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_status", 32'(bus.status_flags), 32'h0);
    chk("rst_ovf_count", 32'(bus.ovf_count), 32'h0);

    // Vector table: one push per cycle, head visible the cycle after the push
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].func, vecs[i].flags, vecs[i].rd, vecs[i].result);
      step();
      chk("vec_out_valid", 32'(bus.out_valid), 32'h1);
      chk("vec_result", bus.out_result, vecs[i].result);
      chk("vec_rd", 32'(bus.out_rd), 32'(vecs[i].rd));
      chk("vec_wen", 32'(bus.out_wen), 32'(vecs[i].exp_wen));
      chk("vec_ovf", 32'(bus.out_ovf_exc), 32'(vecs[i].exp_ovf));
      chk("vec_status", 32'(bus.status_flags), 32'(vecs[i].exp_status));
      chk("vec_ovf_count", 32'(bus.ovf_count), 32'(vecs[i].exp_ovf_cnt));
    end
    drain("vec_drain");

    // Fill to DEPTH with writeback stalled; a further in_valid must be ignored
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 6'h24, 4'h0, 5'(10 + i), 32'(32'hA0 + i));
      step();
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'h0);
    drive(1'b1, 6'h24, 4'h0, 5'd9, 32'hDEAD);
    step();
    chk("full_head_kept", bus.out_result, 32'hA0);
    drain("fill_drain");

    // Overflow count saturation at 8'hFF
    bus.out_ready = 1'b1;
    drive(1'b1, 6'h20, 4'b0001, 5'd8, 32'h7);
    repeat (260) step();
    chk("ovf_sat", 32'(bus.ovf_count), 32'hFF);
    chk("ovf_status_v", 32'(bus.status_flags[0]), 32'h1);
    drain("ovf_drain");

    // Concurrent push/pop at count=2 across pointer wrap
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 6'h24, 4'h0, 5'd12, 32'(32'h200 + i));
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 6'h24, 4'h0, 5'd13, 32'(32'h100 + i));
      step();
      chk("sim_count_held", 32'(mcount), 32'h2);
    end
    drain("sim_drain");

    // Flush with a coincident push at count=3
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h24, 4'h0, 5'd14, 32'(32'h300 + i));
      step();
    end
    bus.flush = 1'b1;
    drive(1'b1, 6'h20, 4'b0111, 5'd15, 32'h333);
    step();
    bus.flush = 1'b0;
    drive(1'b0, 6'h00, 4'h0, 5'd0, 32'h0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'h1);
    chk("flush_status", 32'(bus.status_flags), 32'b1001);
    chk("flush_ovf_count", 32'(bus.ovf_count), 32'hFF);
    step();

    // Reset mid-stream at count=2, then an rd=0 push
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 6'h24, 4'h0, 5'd16, 32'(32'h400 + i));
      step();
    end
    drive(1'b0, 6'h00, 4'h0, 5'd0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("mid_rst_status", 32'(bus.status_flags), 32'h0);
    chk("mid_rst_ovf_count", 32'(bus.ovf_count), 32'h0);
    drive(1'b1, 6'h24, 4'h0, 5'd0, 32'h55);
    step();
    chk("rd0_out_valid", 32'(bus.out_valid), 32'h1);
    chk("rd0_out_wen", 32'(bus.out_wen), 32'h0);
    drain("rd0_drain");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two in the range 2..16.
REQ-003 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port in_valid, input, 1, upstream ALU result valid.
REQ-006 Port in_ready, output, 1, buffer can accept this cycle.
REQ-007 Port in_result, input, 32, ALU result.
REQ-008 Port in_func, input, 6, ALU function code that produced the result.
REQ-009 Port in_flags, input, 4, ALU flags {C,N,Z,V}.
REQ-010 Port in_rd, input, 5, destination register index.
REQ-011 Port flush, input, 1, discard all buffered entries.
REQ-012 Port out_valid, output, 1, head entry valid.
REQ-013 Port out_ready, input, 1, downstream writeback accepts head.
REQ-014 Port out_result, output, 32, head result.
REQ-015 Port out_rd, output, 5, head destination index.
REQ-016 Port out_wen, output, 1, head result is to be written to the register file.
REQ-017 Port out_ovf_exc, output, 1, head entry raised signed-overflow exception.
REQ-018 Port status_flags, output, 4, architectural {C,N,Z,V} status register.
REQ-019 Port ovf_count, output, 8, saturating count of overflow exceptions.

Function
REQ-020 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-021 in_ready SHALL equal (count != DEPTH), combinational from registered count only; in_ready SHALL NOT depend on out_ready.
REQ-022 out_valid SHALL equal (count != 0); out_* data SHALL be driven from the head entry with zero combinational path from in_*.
REQ-023 Latency: an entry pushed at edge N SHALL be visible on out_* in cycle N+1 (one-cycle minimum).
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 Stored ovf bit SHALL be 1 iff in_func is ADD (6'b100000) or SUB (6'b100010) and in_flags[0] (V) is 1.
REQ-027 Stored wen bit SHALL be 1 iff in_rd != 0 and the stored ovf bit is 0.
REQ-028 On push, status_flags SHALL update: ADD/SUB load N,Z,V (C unchanged); ADDU (100001), SUBU (100011), SLL (000000), SLLV (000100), SRL (000010), SRLV (000110) load C only; all other func codes leave status_flags unchanged.
REQ-029 On push with stored ovf=1, ovf_count SHALL increment by 1 and saturate at 8'hFF.
REQ-030 Flush SHALL set count, read and write pointers to 0 at the next edge, has priority over simultaneous push and pop, and SHALL NOT alter status_flags or ovf_count.
REQ-031 Pop when empty and push when full SHALL be impossible by construction; no state change SHALL result from in_valid while in_ready=0.

Reset
REQ-032 When reset=1 at an edge: count, pointers, status_flags=4'b0000, ovf_count=8'h00; hence in_ready=1, out_valid=0.
REQ-033 Reset SHALL take priority over flush, push and pop; entries in flight mid-operation SHALL be discarded.
REQ-034 out_result, out_rd, out_wen and out_ovf_exc SHALL be 0 whenever out_valid=0.

Verification
REQ-035 Single push: in_result=32'h0000_0005, in_func=100000, in_rd=3, flags=4'b0000, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_wen=1, out_ovf_exc=0.
REQ-036 Fill: DEPTH=4, out_ready=0, push 4 entries -> in_ready=0 after 4th; a 5th in_valid is ignored; draining returns the 4 entries in order.
REQ-037 Overflow: ADD with flags V=1, rd=8 -> out_wen=0, out_ovf_exc=1, status_flags[0]=1, ovf_count increments 0->1; 256 such pushes -> ovf_count held at 8'hFF.
REQ-038 Simultaneous: count=2, push and pop in the same cycle -> count stays 2, order preserved across pointer wrap over 10 entries.
REQ-039 Flush with push in the same cycle while count=3 -> count=0, out_valid=0 next cycle, status_flags and ovf_count unchanged.
REQ-040 Reset mid-stream with count=2 -> next cycle out_valid=0, in_ready=1, status_flags=0, ovf_count=0; rd=0 push afterwards yields out_wen=0.
